// File: rtl/i2c_byte_master.sv
// i2c_byte_master
//   Avalon-MM byte-level I2C master. The CPU writes one command and the core
//   sequences START, 8 data bits + ACK/NACK, and STOP on the I2C pins.
//   Build option: define I2C_IRQ_EN to add the irq port (irq = DONE & IRQ_ENA,
//   IRQ_ENA taken from CMD bit 5 on every accepted command).
// Register map (word address):
//   0  W TXDATA[7:0]   R RXDATA[7:0]
//   1  W CMD {NACK[4],READ[3],WRITE[2],STOP[1],START[0]} (+ IRQ_ENA[5])
//      R STATUS {DONE[2],ACKERR[1],BUSY[0]}
//   2  R/W DIV[DIV_W-1:0]; one bit = 4*(DIV+1) clk cycles (DIV=0 acts as 1)
//   3  R 0
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   address, chipselect,  Avalon-MM slave; readdata is registered,
//   write_n, writedata,   one-cycle latency, no wait states
//   readdata
//   sclk                  I2C clock, push-pull, idles high
//   sdat                  I2C data, open-drain (driven 0 or released)
//   irq                   only with I2C_IRQ_EN
module i2c_byte_master #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 124
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] address,
  input  logic       chipselect,
  input  logic       write_n,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       sclk,
`ifdef I2C_IRQ_EN
  output logic       irq,
`endif
  inout  wire        sdat
);

  typedef enum logic [2:0] {IDLE, START_ST, BIT_ST, STOP_ST, DONE_ST} state_t;

  state_t           state, state_next;
  logic [DIV_W-1:0] div, cnt, eff_div;
  logic             tick, wr;
  logic [1:0]       ph;        // quarter-bit phase: 0-1 SCL low, 2-3 SCL high
  logic [3:0]       bit_cnt;   // 0..7 data bits, 8 = ACK/NACK bit
  logic [7:0]       txdata, rxdata, shreg;
  logic             busy, done, ackerr;
  logic             c_start, c_stop, c_write, c_read, c_nack;
  logic             held, held_low;  // bus parked with SCL low after a byte without STOP
  logic             sda_low, ack_drive, bit_drive;

  assign wr      = chipselect & ~write_n;
  assign eff_div = (div == '0) ? DIV_W'(1) : div;
  assign tick    = (cnt == '0);

  // WRITE has priority over READ, so "not write" inside BIT_ST means a read.
  assign ack_drive = c_write ? 1'b0 : ~c_nack;
  assign bit_drive = (bit_cnt == 4'd8) ? ack_drive : (c_write & ~shreg[7]);

  assign sdat = sda_low ? 1'b0 : 1'bz;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would make results depend on block order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: every signal written here gets a default first; a missed branch
  // would otherwise infer a latch.
  always_comb begin
    state_next = state;
    sclk       = 1'b1;
    sda_low    = 1'b0;
    case (state)
      IDLE: begin
        sclk    = ~held;
        sda_low = held & held_low;
        if (busy) begin
          if (c_start)                state_next = START_ST;
          else if (c_write || c_read) state_next = BIT_ST;
          else if (c_stop)            state_next = STOP_ST;
          else                        state_next = DONE_ST;
        end
      end
      START_ST: begin
        // ph0 (only from a held bus): release SDA with SCL low; ph1-2: both
        // high; ph3: SDA low with SCL high. SCL falls on leaving.
        sclk    = (ph != 2'd0);
        sda_low = (ph == 2'd3);
        if (tick && ph == 2'd3) begin
          if (c_write || c_read) state_next = BIT_ST;
          else if (c_stop)       state_next = STOP_ST;
          else                   state_next = DONE_ST;
        end
      end
      BIT_ST: begin
        sclk    = ph[1];
        sda_low = bit_drive;
        if (tick && ph == 2'd3 && bit_cnt == 4'd8)
          state_next = c_stop ? STOP_ST : DONE_ST;
      end
      STOP_ST: begin
        // ph0: SCL low, SDA low; ph1: SCL high, SDA low; SDA released on leaving.
        sclk    = (ph == 2'd1);
        sda_low = 1'b1;
        if (tick && ph == 2'd1) state_next = DONE_ST;
      end
      DONE_ST: begin
        sclk       = ~held;
        sda_low    = held & held_low;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: all storage here is a handful of control/data flops, so every
      // one of them is reset, including the data shifter.
      div      <= DIV_W'(DEFAULT_DIV);
      cnt      <= DIV_W'(DEFAULT_DIV);
      ph       <= 2'd0;
      bit_cnt  <= 4'd0;
      txdata   <= 8'd0;
      rxdata   <= 8'd0;
      shreg    <= 8'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ackerr   <= 1'b0;
      c_start  <= 1'b0;
      c_stop   <= 1'b0;
      c_write  <= 1'b0;
      c_read   <= 1'b0;
      c_nack   <= 1'b0;
      held     <= 1'b0;
      held_low <= 1'b0;
    end else begin
      // Quarter-bit timer; held at reload while idle so a new command
      // starts on a fresh tick boundary.
      if (state == IDLE || tick) cnt <= eff_div;
      else                       cnt <= cnt - 1'b1;

      if (wr && !busy) begin
        case (address)
          2'd0: txdata <= writedata;
          2'd1: begin
            busy    <= 1'b1;
            done    <= 1'b0;
            ackerr  <= 1'b0;
            c_start <= writedata[0];
            c_stop  <= writedata[1];
            c_write <= writedata[2];
            c_read  <= writedata[3];
            c_nack  <= writedata[4];
          end
          2'd2:    div <= DIV_W'(writedata);
          default: ;
        endcase
      end

      case (state)
        IDLE: if (busy) begin
          ph      <= (c_start && !held) ? 2'd1 : 2'd0;
          bit_cnt <= 4'd0;
          shreg   <= txdata;
          if (c_start) held <= 1'b0;
        end
        START_ST: if (tick) ph <= ph + 2'd1;
        BIT_ST: if (tick) begin
          ph <= ph + 2'd1;
          if (ph == 2'd2) begin
            if (bit_cnt != 4'd8) begin
              if (!c_write) shreg <= {shreg[6:0], sdat};
            end else if (c_write && sdat) begin
              ackerr <= 1'b1;
            end
          end
          if (ph == 2'd3) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt != 4'd8) begin
              if (c_write) shreg <= {shreg[6:0], 1'b0};
            end else begin
              if (!c_write) rxdata <= shreg;
              if (!c_stop) begin
                held     <= 1'b1;
                held_low <= ack_drive;
              end
            end
          end
        end
        STOP_ST: if (tick) begin
          ph <= ph + 2'd1;
          if (ph == 2'd1) held <= 1'b0;
        end
        DONE_ST: begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= 8'd0;
    else if (chipselect) begin
      case (address)
        2'd0:    readdata <= rxdata;
        2'd1:    readdata <= {5'd0, done, ackerr, busy};
        2'd2:    readdata <= 8'(div);
        default: readdata <= 8'd0;
      endcase
    end
  end

`ifdef I2C_IRQ_EN
  logic irq_ena;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           irq_ena <= 1'b0;
    else if (wr && !busy && address == 2'd1) irq_ena <= writedata[5];
  end
  assign irq = done & irq_ena;
`endif

endmodule

// File: tb/tb_i2c_byte_master.sv
// tb_i2c_byte_master
//   Directed bench for i2c_byte_master: Avalon register access, a behavioural
//   I2C slave (ACK / no-ACK / read-back modes), bus waveform timing, command
//   blocking while busy, asynchronous reset mid-byte, optional irq.
`timescale 1ns/1ps
module tb_i2c_byte_master;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] address = 2'd0;
  logic       chipselect = 1'b0;
  logic       write_n = 1'b1;
  logic [7:0] writedata = 8'd0;
  logic [7:0] readdata;
  logic       sclk;
  wire        sdat;
`ifdef I2C_IRQ_EN
  logic       irq;
`endif

  logic slave_low = 1'b0;
  assign sdat = slave_low ? 1'b0 : 1'bz;
  pullup (sdat);

  always #5 clk = ~clk;

  i2c_byte_master dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .sclk       (sclk),
`ifdef I2C_IRQ_EN
    .irq        (irq),
`endif
    .sdat       (sdat)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural slave ----------------
  // sl_mode: 0 = ACK writes, 1 = absent (never drives), 2 = return SL_TX.
  localparam logic [7:0] SL_TX = 8'hA5;
  int         sl_mode   = 0;
  int         prime_cnt = 0;   // bumped to make the slave start a byte on a held bus
  int         prime_seen = 0;
  logic       sl_active = 1'b0;
  int         sl_bit    = 0;
  logic [7:0] sl_rx     = 8'd0;
  logic       sl_mack   = 1'b0;
  int         stop_cnt  = 0;
  time        rise_t [9];
  logic       prev_scl  = 1'b1;
  logic       prev_sda  = 1'b1;

  initial begin
    forever begin
      @(sclk or sdat or prime_cnt);
      #1;  // let simultaneous SCL/SDA changes settle before classifying
      if (prime_cnt != prime_seen) begin
        prime_seen = prime_cnt;
        sl_active  = 1'b1;
        sl_bit     = 0;
        slave_low  = (sl_mode == 2) ? ~SL_TX[7] : 1'b0;
      end else if (sclk === 1'b1 && prev_scl === 1'b1 && prev_sda === 1'b1 && sdat === 1'b0) begin
        sl_active = 1'b1;
        sl_bit    = 0;
      end else if (sclk === 1'b1 && prev_scl === 1'b1 && prev_sda === 1'b0 && sdat === 1'b1) begin
        sl_active = 1'b0;
        slave_low = 1'b0;
        stop_cnt++;
      end else if (sclk === 1'b1 && prev_scl === 1'b0 && sl_active) begin
        if (sl_bit < 8)       sl_rx = {sl_rx[6:0], sdat};
        else if (sl_bit == 8) sl_mack = sdat;
        if (sl_bit < 9) begin
          rise_t[sl_bit] = $time;
          sl_bit++;
        end
      end else if (sclk === 1'b0 && prev_scl === 1'b1 && sl_active) begin
        case (sl_mode)
          0:       slave_low = (sl_bit == 8);
          1:       slave_low = 1'b0;
          default: slave_low = (sl_bit < 8) ? ~SL_TX[7 - sl_bit] : 1'b0;
        endcase
      end
      prev_scl = sclk;
      prev_sda = sdat;
    end
  end

  // ---------------- Avalon helpers (call just after a falling clk edge) ----------------
  task automatic av_write(input logic [1:0] a, input logic [7:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic av_read(input logic [1:0] a, output logic [7:0] d);
    address = a; chipselect = 1'b1;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic wait_idle(output logic [7:0] st);
    st = 8'h01;
    for (int i = 0; i < 3000 && st[0]; i++) av_read(2'd1, st);
    check("busy_clears", {31'd0, st[0]}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] st, rd;
    int stops0;

    // ---- reset state ----
    #23;
    check("rst_sclk", sclk, 1'b1);
    check("rst_sdat_released", sdat, 1'b1);
    check("rst_readdata", readdata, 8'h00);
`ifdef I2C_IRQ_EN
    check("rst_irq", irq, 1'b0);
`endif
    @(negedge clk); reset_n = 1'b1; @(negedge clk);
    av_read(2'd1, st); check("rst_status", st, 8'h00);
    av_read(2'd2, rd); check("rst_div", rd, 8'd124);
    av_read(2'd0, rd); check("rst_rxdata", rd, 8'h00);
    av_read(2'd3, rd); check("addr3_zero", rd, 8'h00);

    // ---- write 0x34 with START+WRITE+STOP, ACKing slave, DIV=3 ----
    sl_mode = 0;
    av_write(2'd2, 8'd3);
    av_write(2'd0, 8'h34);
    stops0 = stop_cnt;
    av_write(2'd1, 8'h07);
    wait_idle(st);
    check("wr_status", st, 8'h04);
    check("wr_byte_on_bus", sl_rx, 8'h34);
    check("wr_bit_time", 32'(rise_t[1] - rise_t[0]), 32'd160);
    check("wr_9bit_span", 32'(rise_t[8] - rise_t[0]), 32'd1280);
    check("wr_stop_seen", stop_cnt - stops0, 1);
    check("wr_idle_sclk", sclk, 1'b1);
    check("wr_idle_sdat", sdat, 1'b1);

    // ---- no slave: START+WRITE, no STOP -> ACKERR, bus held ----
    sl_mode = 1;
    av_write(2'd1, 8'h05);
    wait_idle(st);
    check("nack_status", st, 8'h06);
    check("held_sclk_low", sclk, 1'b0);
    check("held_sdat", sdat, 1'b1);

    // ---- read 0xA5 on the held bus, NACK + STOP ----
    sl_mode = 2;
    prime_cnt++;
    stops0 = stop_cnt;
    av_write(2'd1, 8'h1A);
    wait_idle(st);
    check("rd_status", st, 8'h04);
    av_read(2'd0, rd); check("rd_rxdata", rd, 8'hA5);
    check("rd_master_nack", sl_mack, 1'b1);
    check("rd_stop_seen", stop_cnt - stops0, 1);

    // ---- command with no action bits: DONE two cycles after the write ----
    av_write(2'd1, 8'h00);
    av_read(2'd1, st); check("noop_st_c1", st, 8'h01);
    av_read(2'd1, st); check("noop_st_c2", st, 8'h01);
    av_read(2'd1, st); check("noop_st_c3", st, 8'h04);

    // ---- writes while busy are ignored ----
    sl_mode = 0;
    av_write(2'd0, 8'h5A);
    stops0 = stop_cnt;
    av_write(2'd1, 8'h07);
    av_write(2'd1, 8'h07);
    av_write(2'd2, 8'd0);
    av_write(2'd0, 8'hFF);
    wait_idle(st);
    check("busy_status", st, 8'h04);
    check("busy_byte", sl_rx, 8'h5A);
    check("busy_bit_time", 32'(rise_t[1] - rise_t[0]), 32'd160);
    check("busy_one_stop", stop_cnt - stops0, 1);
    av_read(2'd2, rd); check("busy_div_kept", rd, 8'd3);
    av_write(2'd1, 8'h07);
    wait_idle(st);
    check("busy_tx_kept", sl_rx, 8'h5A);

    // ---- asynchronous reset mid-byte (bit 2 of 0x5A is 0) ----
    av_write(2'd1, 8'h07);
    repeat (47) @(negedge clk);
    check("mid_sclk_low", sclk, 1'b0);
    check("mid_sdat_low", sdat, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("async_sclk_high", sclk, 1'b1);
    check("async_sdat_released", sdat, 1'b1);
    @(negedge clk); reset_n = 1'b1; @(negedge clk);
    av_read(2'd1, st); check("post_rst_status", st, 8'h00);
    av_read(2'd2, rd); check("post_rst_div", rd, 8'd124);
    av_write(2'd2, 8'd3);
    stops0 = stop_cnt;
    av_write(2'd1, 8'h02);
    wait_idle(st);
    check("recover_status", st, 8'h04);
    check("recover_stop_seen", stop_cnt - stops0, 1);
    check("recover_sdat", sdat, 1'b1);

`ifdef I2C_IRQ_EN
    // ---- irq follows DONE when CMD bit 5 is set ----
    av_write(2'd1, 8'h20);
    repeat (3) @(negedge clk);
    check("irq_set", irq, 1'b1);
    av_write(2'd1, 8'h00);
    check("irq_cleared", irq, 1'b0);
    repeat (3) @(negedge clk);
    check("irq_disabled", irq, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
